// File: rtl/fan_pkg.sv
// Shared constants and the collector FSM state type for the fan_tree output path.
package fan_pkg;

  // Leaf count of the reduction tree and the output-slot geometry derived from it.
  localparam int N        = 32;
  localparam int N_ADDERS = N - 1;
  localparam int N_SLOTS  = 2 * N_ADDERS;
  localparam int IDX_W    = $clog2(N_SLOTS);

  // The collector is either waiting for a vector or emitting its masked words.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage : fan_pkg

// File: rtl/fan_lsb_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant 1 in
// mask_i and whether any bit is set. Purely combinational so it can sit in
// front of a mask register without adding latency.
module fan_lsb_enc
  import fan_pkg::*;
#(
  parameter int W  = N_SLOTS,
  parameter int IW = IDX_W
) (
  input  logic [W-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule : fan_lsb_enc

// File: rtl/fan_collector.sv
// Serialises the valid slots of one fan_tree output vector into a stream of
// single-word beats, lowest slot first. A new vector may be accepted on the
// handshake of the previous vector's last beat, so back-to-back vectors
// stream without an idle cycle.
module fan_collector
  import fan_pkg::state_e;
  import fan_pkg::IDLE;
  import fan_pkg::DRAIN;
#(
  parameter int DW_DATA = 8,
  parameter int N       = fan_pkg::N,
  localparam int N_ADDERS = N - 1,
  localparam int N_SLOTS  = 2 * N_ADDERS,
  localparam int IDX_W    = $clog2(N_SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_SLOTS-1:0]         in_mask,
  input  logic [DW_DATA*N_SLOTS-1:0] in_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DW_DATA-1:0]         o_data,
  output logic [IDX_W-1:0]           o_idx,
  output logic                       o_last,
  output logic                       busy
);

  localparam logic [N_SLOTS-1:0] MASK_ONE = {{(N_SLOTS - 1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [N_SLOTS-1:0]         mask_q, mask_d;
  logic [DW_DATA*N_SLOTS-1:0] data_q, data_d;

  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_any;
  logic             draining;
  logic             one_left;
  logic             accept;

  // Pick the next slot to present from what remains of the registered mask.
  fan_lsb_enc #(
    .W  (N_SLOTS),
    .IW (IDX_W)
  ) u_lsb_enc (
    .mask_i (mask_q),
    .idx_o  (lsb_idx),
    .any_o  (lsb_any)
  );

  assign draining = (state_q == DRAIN);

  // Clearing the lowest set bit leaves zero only when a single bit remains.
  assign one_left = lsb_any && ((mask_q & (mask_q - MASK_ONE)) == '0);

  // Reset holds in_ready low so nothing is accepted while the state is forced.
  assign in_ready = !rst && (!draining || (o_ready && one_left));
  assign accept   = in_valid && in_ready;

  // Outputs are gated by state so an idle collector presents all zeros.
  assign o_valid = draining;
  assign busy    = draining;
  assign o_last  = draining && one_left;
  assign o_idx   = draining ? lsb_idx : '0;
  assign o_data  = draining ? data_q[DW_DATA*lsb_idx +: DW_DATA] : '0;

  // Next-state logic: load on acceptance, retire one slot per handshake.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // An all-zero mask is consumed here without ever leaving IDLE.
        if (accept && (|in_mask)) begin
          state_d = DRAIN;
          mask_d  = in_mask;
          data_d  = in_data;
        end
      end
      DRAIN: begin
        if (o_ready) begin
          if (one_left) begin
            if (accept) begin
              // Overlap the final beat with loading the next vector.
              mask_d  = in_mask;
              state_d = (|in_mask) ? DRAIN : IDLE;
              if (|in_mask) begin
                data_d = in_data;
              end
            end else begin
              mask_d  = '0;
              state_d = IDLE;
            end
          end else begin
            mask_d = mask_q & (mask_q - MASK_ONE);
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // State, mask and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

endmodule : fan_collector

// File: tb/tb_fan_collector.sv
// Self-checking bench for fan_collector: expected beats are queued when a
// vector is driven and compared as the collector hands them out.
module tb_fan_collector;

  localparam int DW = 8;
  localparam int NS = 62;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [5:0]    idx;
    logic          last;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NS-1:0]    in_mask;
  logic [DW*NS-1:0] in_data;
  logic             o_valid;
  logic             o_ready;
  logic [DW-1:0]    o_data;
  logic [5:0]       o_idx;
  logic             o_last;
  logic             busy;

  beat_t            exp_q[$];
  logic [DW*NS-1:0] data_v;
  int               errors;
  int               checks;

  fan_collector #(
    .DW_DATA (DW),
    .N       (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mask  (in_mask),
    .in_data  (in_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_last   (o_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slot k carries k + off (or random words when rnd is set).
  task automatic fill_data(input int off, input bit rnd);
    for (int k = 0; k < NS; k++) begin
      data_v[DW*k +: DW] = rnd ? DW'($urandom_range(0, 255)) : DW'(k + off);
    end
  endtask

  // Queue the beats a vector should produce, ascending slot order.
  task automatic push_expected(input logic [NS-1:0] m, input logic [DW*NS-1:0] d);
    int hi;
    beat_t b;
    hi = -1;
    for (int k = 0; k < NS; k++) if (m[k]) hi = k;
    for (int k = 0; k < NS; k++) begin
      if (m[k]) begin
        b.data = d[DW*k +: DW];
        b.idx  = 6'(k);
        b.last = (k == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; o_ready = 1'b0;
    step(); step(); #1;
    checks++;
    if ({o_valid, o_last, busy, in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got v/l/b/r=%b expected 0000", {o_valid, o_last, busy, in_ready});
    end
    checks++;
    if ({o_data, o_idx} !== 14'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%0h idx=%0d expected 0/0", o_data, o_idx);
    end
    step(); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b o_valid=%b expected 1/0", in_ready, o_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [NS-1:0] m;
    beat_t e;
    m = '0; m[2] = 1'b1; m[5] = 1'b1; m[40] = 1'b1;
    fill_data(100, 1'b0);
    step(); in_valid = 1'b1; in_mask = m; in_data = data_v; o_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: got in_ready=%b expected 1", in_ready);
    end
    push_expected(m, data_v);
    for (int c = 1; c <= 3; c++) begin
      step(); in_valid = 1'b0; #1;
      checks++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL basic_valid: cycle t+%0d got o_valid=%b expected 1", c, o_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({o_data, o_idx, o_last} !== e) begin
          errors++;
          $display("FAIL basic_beat: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                   o_data, o_idx, o_last, e.data, e.idx, e.last);
        end
        $display("basic beat data=%0d idx=%0d last=%b", o_data, o_idx, o_last);
      end
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL basic_last_ready: got in_ready=%b expected 1", in_ready);
        end
      end
    end
    step(); #1;
    checks++;
    if (o_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got v/r/b=%b%b%b expected 010", o_valid, in_ready, busy);
    end
  endtask

  task automatic test_stall();
    logic [NS-1:0] m;
    beat_t e;
    logic [14:0] snap;
    logic stalled;
    int beats;
    m = '0; m[2] = 1'b1; m[5] = 1'b1; m[40] = 1'b1;
    fill_data(100, 1'b0);
    step(); in_valid = 1'b1; in_mask = m; in_data = data_v; o_ready = 1'b0; #1;
    push_expected(m, data_v);
    stalled = 1'b0; beats = 0; snap = '0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(); in_valid = 1'b0; o_ready = c[0]; #1;
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid: cycle %0d got o_valid=%b expected 1", c, o_valid);
      end
      if (stalled) begin
        checks++;
        if ({o_data, o_idx, o_last} !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %0h expected %0h", {o_data, o_idx, o_last}, snap);
        end
      end
      if (o_ready && o_valid) begin
        e = exp_q.pop_front();
        beats++;
        checks++;
        if ({o_data, o_idx, o_last} !== e) begin
          errors++;
          $display("FAIL stall_beat: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                   o_data, o_idx, o_last, e.data, e.idx, e.last);
        end
        $display("stall beat data=%0d idx=%0d last=%b", o_data, o_idx, o_last);
        stalled = 1'b0;
      end else begin
        snap = {o_data, o_idx, o_last};
        stalled = 1'b1;
      end
    end
    checks++;
    if (beats != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got beats=%0d left=%0d expected 3/0", beats, exp_q.size());
    end
    exp_q.delete();
    step(); o_ready = 1'b1; #1;
    checks++;
    if (o_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle: got o_valid=%b in_ready=%b expected 0/1", o_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] m_a, m_b;
    beat_t e;
    m_a = '0; m_a[0] = 1'b1;
    fill_data(7, 1'b0);
    step(); in_valid = 1'b1; in_mask = m_a; in_data = data_v; o_ready = 1'b1; #1;
    push_expected(m_a, data_v);
    m_b = '0; m_b[61] = 1'b1;
    fill_data(50, 1'b0);
    step(); in_valid = 1'b1; in_mask = m_b; in_data = data_v; #1;
    checks++;
    if (o_valid !== 1'b1 || in_ready !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_overlap: got o_valid=%b in_ready=%b expected 1/1", o_valid, in_ready);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({o_data, o_idx, o_last} !== e) begin
        errors++;
        $display("FAIL b2b_beat_a: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                 o_data, o_idx, o_last, e.data, e.idx, e.last);
      end
      $display("b2b beat A data=%0d idx=%0d last=%b", o_data, o_idx, o_last);
    end
    push_expected(m_b, data_v);
    step(); in_valid = 1'b0; #1;
    checks++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_gap: got o_valid=%b expected 1", o_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({o_data, o_idx, o_last} !== e) begin
        errors++;
        $display("FAIL b2b_beat_b: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                 o_data, o_idx, o_last, e.data, e.idx, e.last);
      end
      $display("b2b beat B data=%0d idx=%0d last=%b", o_data, o_idx, o_last);
    end
    exp_q.delete();
    step(); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got o_valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_zero_mask();
    fill_data(1, 1'b0);
    step(); in_valid = 1'b1; in_mask = '0; in_data = data_v; o_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept: got in_ready=%b expected 1", in_ready);
    end
    for (int c = 1; c <= 2; c++) begin
      step(); in_valid = 1'b0; #1;
      checks++;
      if (o_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_idle: cycle %0d got v/r/b=%b%b%b expected 010", c, o_valid, in_ready, busy);
      end
    end
    $display("zero mask vector dropped");
  endtask

  task automatic test_all_ones_reset();
    logic [NS-1:0] m;
    beat_t e;
    int beats;
    m = '1;
    fill_data(0, 1'b1);
    step(); in_valid = 1'b1; in_mask = m; in_data = data_v; o_ready = 1'b1; #1;
    push_expected(m, data_v);
    beats = 0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      step(); in_valid = 1'b0; #1;
      if (o_valid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL ones_valid: cycle %0d got o_valid=%b expected 1", c, o_valid);
      end else begin
        e = exp_q.pop_front();
        beats++;
        checks++;
        if ({o_data, o_idx, o_last} !== e) begin
          errors++;
          $display("FAIL ones_beat: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                   o_data, o_idx, o_last, e.data, e.idx, e.last);
        end
        $display("ones beat data=%0d idx=%0d last=%b", o_data, o_idx, o_last);
      end
    end
    checks++;
    if (beats != NS) begin
      errors++;
      $display("FAIL ones_count: got %0d beats expected %0d", beats, NS);
    end
    exp_q.delete();
    fill_data(0, 1'b1);
    step(); in_valid = 1'b1; in_mask = m; in_data = data_v; #1;
    push_expected(m, data_v);
    for (int c = 0; c < 10; c++) begin
      step(); in_valid = 1'b0; #1;
      e = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || {o_data, o_idx, o_last} !== e) begin
        errors++;
        $display("FAIL ones2_beat: got v=%b data=%0d idx=%0d expected data=%0d idx=%0d",
                 o_valid, o_data, o_idx, e.data, e.idx);
      end
    end
    step(); rst = 1'b1; #1;
    checks++;
    if ({o_valid, o_last, busy, in_ready} !== 4'b0000 || {o_data, o_idx} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_hold: got v/l/b/r=%b data=%0h idx=%0d expected 0000/0/0",
               {o_valid, o_last, busy, in_ready}, o_data, o_idx);
    end
    exp_q.delete();
    step(); rst = 1'b0; #1;
    checks++;
    if (o_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: got o_valid=%b in_ready=%b expected 0/1", o_valid, in_ready);
    end
    $display("mid-drain reset discarded remaining beats");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    data_v = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_zero_mask();
    test_all_ones_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fan_collector

// File: doc/fan_collector.md
FAN_COLLECTOR -- requirements
Module: fan_collector

Interface
REQ-001 The parameter DW_DATA SHALL default to 8 and set the width of one tree output word.
REQ-002 The parameter N SHALL default to 32 and set the number of fan_tree leaves; N_ADDERS = N-1 and N_SLOTS = 2*N_ADDERS (62) SHALL be derived from it.
REQ-003 The port list SHALL be, in order:
  clk  input  1  the single clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  in_valid  input  1  the tree output vector is valid.
  in_ready  output  1  the collector accepts the vector this cycle.
  in_mask  input  N_SLOTS  fan_tree out_valid, one bit per output slot.
  in_data  input  DW_DATA*N_SLOTS  fan_tree out; slot k occupies bits [DW_DATA*k +: DW_DATA].
  o_valid  output  1  a reduced sum is presented.
  o_ready  input  1  the downstream accepts it.
  o_data  output  DW_DATA  the reduced sum.
  o_idx  output  IDX_W (6)  the source slot index of o_data.
  o_last  output  1  the final sum of the current vector.
  busy  output  1  the collector holds an undrained vector.

Function
REQ-004 The collector SHALL serialise every slot whose in_mask bit is 1 into o_data beats, in ascending slot order, one beat per o_valid&&o_ready handshake.
REQ-005 The FSM SHALL have two states, IDLE and DRAIN.
REQ-006 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready with a nonzero in_mask, the collector SHALL register in_mask and in_data and enter DRAIN on the next edge.
REQ-007 An accepted vector with in_mask==0 SHALL be consumed and dropped; the FSM SHALL stay in IDLE and produce no beat.
REQ-008 The first o_valid SHALL assert exactly one cycle after acceptance (latency 1); o_valid SHALL equal (state==DRAIN).
REQ-009 In DRAIN, o_idx SHALL be the lowest set bit of the registered mask, and o_data SHALL be the registered word at that slot.
REQ-010 o_last SHALL be 1 when exactly one bit remains in the registered mask.
REQ-011 On each handshake, the collector SHALL clear the presented bit; o_valid, o_data, o_idx and o_last SHALL hold stable while o_ready is 0.
REQ-012 On the handshake of the o_last beat, in_ready SHALL be 1 in that same cycle. A simultaneous in_valid SHALL load the new vector with no bubble (nonzero mask: remain in DRAIN; zero mask: go to IDLE). Otherwise the FSM SHALL go to IDLE.
REQ-013 In DRAIN, except on the final-beat handshake, in_ready SHALL be 0.
REQ-014 busy SHALL equal (state==DRAIN).
REQ-015 A vector with all N_SLOTS bits set SHALL produce exactly N_SLOTS beats, indices 0..61, with o_last on index 61.
REQ-016 Data SHALL pass unmodified, with no arithmetic or width change.

Reset
REQ-017 While rst=1, the state SHALL be IDLE, the registered mask and data SHALL be 0, o_valid/o_last/busy SHALL be 0, o_idx and o_data SHALL be 0, and in_ready SHALL be 0.
REQ-018 Reset asserted mid-DRAIN SHALL discard the remaining beats; the first cycle after rst falls SHALL show in_ready=1 and o_valid=0.

Structure
REQ-019 The package fan_pkg SHALL hold N, N_ADDERS, N_SLOTS, IDX_W, and the FSM state type.
REQ-020 The lowest-set-bit search SHALL be a combinational sub-module, fan_lsb_enc (mask in; index and any-set out), reused by fan-side config logic.

Verification
REQ-021 Mask bits {2,5,40} set with data slot k = k+100, o_ready=1 -> beats (102,2), (105,5), (140,40) on cycles t+1..t+3, o_last only on the third, then in_ready=1.
REQ-022 Same vector, o_ready toggling 0/1 each cycle -> the same three beats in order, outputs stable during stalls, no beat lost or duplicated.
REQ-023 Vector A = mask {0}, then vector B = mask {61} presented on A's last-beat cycle -> B accepted that cycle, B's beat (idx 61) on the next cycle, no idle gap.
REQ-024 in_mask=0 with in_valid=1 -> accepted in one cycle, o_valid stays 0, in_ready stays 1.
REQ-025 All-ones mask -> 62 beats, indices 0..61, o_last on 61; then rst pulsed after the 10th beat of a second all-ones vector -> o_valid=0 and in_ready=1 on the first post-reset cycle.
